// File: rtl/timetag_acquire.sv
// timetag_acquire
//   Photon event tagger. Each strobe (click) input and each delta (level)
//   input is synchronised. Rising strobe edges and delta level changes are
//   stamped with a free-running timestamp. The resulting records are queued
//   in a first-word-fallthrough FIFO that the consumer drains over a
//   valid/ack handshake.
//
//   Record layout: {wrap, lost, delta[ND-1:0], strobe[NS-1:0], timestamp[TW-1:0]}
//
//   Optional feature macro: TIMETAG_WRAP_MARKER_EN
//     When defined, each counter wrap emits a record with wrap=1.
//     When undefined, the wrap bit is tied to 0.
//
// Ports
//   clk           system clock, rising edge
//   reset         synchronous active-high reset, clears all state
//   operate       acquisition enable (events and counter increment)
//   reset_counter synchronous clear of the timestamp counter only
//   strobe_in     asynchronous click inputs (NS)
//   delta_in      asynchronous level inputs (ND)
//   data_rdy      FIFO head valid
//   data          FIFO head record (RW bits), zero when empty
//   data_ack      pop the head when data_rdy is high
//   lost_count    records dropped on a full FIFO, saturating
//   fifo_level    current FIFO occupancy
module timetag_acquire #(
    parameter int TW    = 37,
    parameter int NS    = 4,
    parameter int ND    = 4,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH),
    localparam int RW   = TW + NS + ND + 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          operate,
    input  logic          reset_counter,
    input  logic [NS-1:0] strobe_in,
    input  logic [ND-1:0] delta_in,
    output logic          data_rdy,
    output logic [RW-1:0] data,
    input  logic          data_ack,
    output logic [15:0]   lost_count,
    output logic [AW:0]   fifo_level
);

    logic [NS-1:0] strobe_s1, strobe_s2, strobe_s3;
    logic [ND-1:0] delta_s1, delta_s2, delta_s3;
    logic [TW-1:0] counter;
    logic          wrap_ev;
    logic [NS-1:0] strobe_ev;
    logic          delta_ev;
    logic          any_ev;
    logic          pop;
    logic          full;
    logic          wr_ok;
    logic          drop;
    logic          lost_pending;
    logic [RW-1:0] record;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [RW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            strobe_s1 <= '0;
            strobe_s2 <= '0;
            strobe_s3 <= '0;
            delta_s1  <= '0;
            delta_s2  <= '0;
            delta_s3  <= '0;
        end else begin
            strobe_s1 <= strobe_in;
            strobe_s2 <= strobe_s1;
            strobe_s3 <= strobe_s2;
            delta_s1  <= delta_in;
            delta_s2  <= delta_s1;
            delta_s3  <= delta_s2;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || reset_counter) begin
            counter <= '0;
        end else if (operate) begin
            counter <= counter + TW'(1);
        end
    end

`ifdef TIMETAG_WRAP_MARKER_EN
    // Flags the all-ones -> 0 increment so that the marker lands in the cycle
    // where the counter reads 0, giving the marker record timestamp 0.
    logic wrap_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= operate && !reset_counter && (counter == '1);
        end
    end

    assign wrap_ev = wrap_q;
`else
    assign wrap_ev = 1'b0;
`endif

    assign strobe_ev = strobe_s2 & ~strobe_s3 & {NS{operate}};
    assign delta_ev  = operate && (delta_s2 != delta_s3);
    assign any_ev    = (|strobe_ev) || delta_ev || wrap_ev;

    assign data_rdy = (fifo_level != '0);
    assign pop      = data_rdy && data_ack;
    assign full     = (fifo_level == (AW+1)'(DEPTH));
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign wr_ok    = any_ev && (!full || pop);
    assign drop     = any_ev && full && !pop;

    assign record = {wrap_ev, lost_pending, delta_s2, strobe_ev, counter};

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= record;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_level   <= '0;
            lost_pending <= 1'b0;
            lost_count   <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (wr_ok && !pop) begin
                fifo_level <= fifo_level + (AW+1)'(1);
            end else if (pop && !wr_ok) begin
                fifo_level <= fifo_level - (AW+1)'(1);
            end
            if (drop) begin
                lost_pending <= 1'b1;
                if (lost_count != 16'hFFFF) begin
                    lost_count <= lost_count + 16'd1;
                end
            end else if (wr_ok) begin
                lost_pending <= 1'b0;
            end
        end
    end

    assign data = data_rdy ? mem[rd_ptr] : '0;

endmodule
